// File: rtl/pipelined_shifter.sv
// pipelined_shifter: LAT-stage shift/rotate pipeline; stage k applies a displacement of 2^k.
// Define PIPELINED_SHIFTER_ROTATE_EN to build ROL/ROR; otherwise modes 011/100 are reserved.
module pipelined_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_mode_err
);
    localparam int LAT = AMT_W;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    localparam logic [2:0] MAX_MODE = 3'd4;
`else
    localparam logic [2:0] MAX_MODE = 3'd2;
`endif
    logic             v_q  [LAT];
    logic [WIDTH-1:0] d_q  [LAT];
    logic [2:0]       m_q  [LAT];
    logic [AMT_W-1:0] a_q  [LAT];
    logic             e_q  [LAT];
    logic             z_q;
    logic             v_in [LAT];
    logic [WIDTH-1:0] d_in [LAT];
    logic [2:0]       m_in [LAT];
    logic [AMT_W-1:0] a_in [LAT];
    logic             e_in [LAT];
    logic [WIDTH-1:0] d_nx [LAT];
    logic             stall;

    // Reserved modes fall through unchanged, so the error flag alone marks them.
    function automatic logic [WIDTH-1:0] displace(input logic [WIDTH-1:0] d, input logic [2:0] m, input int s);
        logic signed [WIDTH-1:0] sd;
        logic [WIDTH-1:0] r;
        sd = $signed(d) >>> s;
        r = m == 3'd0 ? d << s : m == 3'd1 ? d >> s : m == 3'd2 ? sd : d;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        if (m == 3'd3) r = (d << s) | (d >> (WIDTH - s));
        if (m == 3'd4) r = (d >> s) | (d << (WIDTH - s));
`endif
        return r;
    endfunction

    assign stall        = v_q[LAT-1] && !out_ready;
    assign in_ready     = !reset && !stall;
    assign out_valid    = v_q[LAT-1];
    assign out_data     = d_q[LAT-1];
    assign out_zero     = z_q;
    assign out_mode_err = e_q[LAT-1];

    always_comb begin
        v_in[0] = in_valid;
        d_in[0] = in_data;
        m_in[0] = in_mode;
        a_in[0] = in_amt;
        e_in[0] = in_mode > MAX_MODE;
        for (int k = 1; k < LAT; k++) begin
            v_in[k] = v_q[k-1];
            d_in[k] = d_q[k-1];
            m_in[k] = m_q[k-1];
            a_in[k] = a_q[k-1];
            e_in[k] = e_q[k-1];
        end
        for (int k = 0; k < LAT; k++)
            d_nx[k] = a_in[k][k] ? displace(d_in[k], m_in[k], 1 << k) : d_in[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) begin
                v_q[k] <= 1'b0;
                d_q[k] <= '0;
                m_q[k] <= '0;
                a_q[k] <= '0;
                e_q[k] <= 1'b0;
            end
            z_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < LAT; k++) begin
                v_q[k] <= v_in[k];
                d_q[k] <= d_nx[k];
                m_q[k] <= m_in[k];
                a_q[k] <= a_in[k];
                e_q[k] <= e_in[k];
            end
            z_q <= d_nx[LAT-1] == '0;
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: randomized and directed checks of pipelined_shifter against a behavioural model.
module tb_pipelined_shifter;
    localparam int LAT = 3;
    localparam int LAT32 = 5;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    localparam logic [2:0] MAXM = 3'd4;
`else
    localparam logic [2:0] MAXM = 3'd2;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_zero, out_mode_err;
    logic [7:0] in_data = '0, out_data;
    logic [2:0] in_amt = '0, in_mode = '0;
    logic w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b1, w_out_zero, w_out_mode_err;
    logic [31:0] w_in_data = '0, w_out_data;
    logic [4:0] w_in_amt = '0;
    logic [2:0] w_in_mode = '0;
    int checks = 0, errors = 0;
    logic [9:0] exp_q[$], got_q[$];
    bit acc;

    always #5 clk = ~clk;

    pipelined_shifter dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_mode_err(out_mode_err)
    );

    pipelined_shifter #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .in_amt(w_in_amt), .in_mode(w_in_mode), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .out_zero(w_out_zero), .out_mode_err(w_out_mode_err)
    );

    // Result = {mode_err, zero, data}, straight from the shift/rotate definitions.
    function automatic logic [9:0] model(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m);
        logic [15:0] dd, sx;
        logic [7:0] r;
        dd = {d, d};
        sx = {{8{d[7]}}, d};
        r = d;
        if (m <= MAXM)
            case (m)
                3'd0: r = d << a;
                3'd1: r = d >> a;
                3'd2: r = 8'(sx >> a);
                3'd3: r = 8'((dd << a) >> 8);
                3'd4: r = 8'(dd >> a);
                default: r = d;
            endcase
        return {m > MAXM, r == 8'd0, r};
    endfunction

    task automatic step(output bit accepted);
        @(negedge clk);
        accepted = !reset && in_valid && in_ready;
        if (accepted) exp_q.push_back(model(in_data, in_amt, in_mode));
        if (!reset && out_valid && out_ready) got_q.push_back({out_mode_err, out_zero, out_data});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hFF;
        step(acc);
        step(acc);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if ({out_mode_err, out_zero, out_data} !== 10'd0) begin errors++; $display("FAIL reset_outputs got %h expected 000", {out_mode_err, out_zero, out_data}); end
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        for (int i = 0; i < LAT + 1; i++) begin
            step(acc);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_word_leak got out_valid %b expected 0", out_valid); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_directed();
        logic [7:0] vd [8] = '{8'h81, 8'h80, 8'h90, 8'h01, 8'h81, 8'h01, 8'h5A, 8'hF0};
        logic [2:0] va [8] = '{3'd1, 3'd7, 3'd2, 3'd1, 3'd1, 3'd3, 3'd5, 3'd0};
        logic [2:0] vm [8] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd7, 3'd2};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        logic [9:0] ve [8] = '{10'h002, 10'h001, 10'h0E4, 10'h100, 10'h003, 10'h020, 10'h25A, 10'h0F0};
`else
        logic [9:0] ve [8] = '{10'h002, 10'h001, 10'h0E4, 10'h100, 10'h281, 10'h201, 10'h25A, 10'h0F0};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = vd[i];
            in_amt = va[i];
            in_mode = vm[i];
            step(acc);
            in_valid = 1'b0;
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got %b expected 1", i, acc); end
            for (int j = 0; j < LAT - 2; j++) step(acc);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early got out_valid %b expected 0", i, out_valid); end
            step(acc);
            checks++; if (out_valid !== 1'b1 || {out_mode_err, out_zero, out_data} !== ve[i])
                begin errors++; $display("FAIL dir%0d_result got v=%b %h expected v=1 %h", i, out_valid, {out_mode_err, out_zero, out_data}, ve[i]); end
            step(acc);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_data = 8'($urandom);
            in_amt = 3'($urandom_range(0, 7));
            in_mode = 3'($urandom_range(0, 7));
            #1;
            checks++; if (in_ready !== !(out_valid && !out_ready)) begin errors++; $display("FAIL rand_in_ready cycle %0d got %b", c, in_ready); end
            step(acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < LAT + 3; c++) step(acc);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (got_q[i]) if (i < exp_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] wd [8];
        logic [2:0] wa [8], wm [8];
        logic [9:0] held = '0;
        int sent = 0, n;
        int out_cyc[$];
        for (int i = 0; i < 8; i++) begin
            wd[i] = 8'($urandom);
            wa[i] = 3'($urandom_range(1, 7));
            wm[i] = 3'($urandom_range(0, 2));
        end
        for (int c = 0; c < 20; c++) begin
            in_valid = sent < 8;
            if (sent < 8) begin
                in_data = wd[sent];
                in_amt = wa[sent];
                in_mode = wm[sent];
            end
            out_ready = !(c >= 5 && c <= 8);
            #1;
            if (c == 5) held = {out_mode_err, out_zero, out_data};
            if (c >= 5 && c <= 8) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready cycle %0d got %b expected 0", c, in_ready); end
                checks++; if ({out_mode_err, out_zero, out_data} !== held || out_valid !== 1'b1)
                    begin errors++; $display("FAIL b2b_hold cycle %0d got v=%b %h expected v=1 %h", c, out_valid, {out_mode_err, out_zero, out_data}, held); end
            end
            n = got_q.size();
            step(acc);
            if (acc) sent++;
            if (got_q.size() > n) out_cyc.push_back(c);
        end
        in_valid = 1'b0;
        checks++; if (sent != 8 || out_cyc.size() != 8) begin errors++; $display("FAIL b2b_count got sent %0d out %0d expected 8 8", sent, out_cyc.size()); end
        foreach (out_cyc[i]) begin
            checks++; if (out_cyc[i] != (i < 2 ? 3 + i : 7 + i)) begin errors++; $display("FAIL b2b_timing word%0d got cycle %0d expected %0d", i, out_cyc[i], i < 2 ? 3 + i : 7 + i); end
        end
        foreach (got_q[i]) if (i < exp_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic [9:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            in_amt = 3'($urandom_range(1, 7));
            in_mode = 3'd0;
            step(acc);
        end
        in_data = 8'hA5;
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b expected 0", in_ready); end
        step(acc);
        reset = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b expected 0", out_valid); end
        for (int i = 0; i < LAT + 3; i++) begin
            step(acc);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_leak cycle %0d got out_valid %b expected 0", i, out_valid); end
        end
        exp_q.delete();
        got_q.delete();
        in_valid = 1'b1;
        in_data = 8'($urandom);
        in_amt = 3'($urandom_range(0, 7));
        in_mode = 3'($urandom_range(0, 2));
        e = model(in_data, in_amt, in_mode);
        step(acc);
        in_valid = 1'b0;
        for (int j = 0; j < LAT - 1; j++) step(acc);
        checks++; if (out_valid !== 1'b1 || {out_mode_err, out_zero, out_data} !== e)
            begin errors++; $display("FAIL mid_reset_first got v=%b %h expected v=1 %h", out_valid, {out_mode_err, out_zero, out_data}, e); end
        step(acc);
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_width32();
        logic [31:0] vd [3] = '{32'h00000081, 32'h00000080, 32'h80000000};
        logic [2:0] vm [3] = '{3'd0, 3'd1, 3'd2};
        logic [33:0] ve [3] = '{{2'b00, 32'h80000000}, {2'b01, 32'h00000000}, {2'b00, 32'hFFFFFFFF}};
        for (int i = 0; i < 3; i++) begin
            w_in_valid = 1'b1;
            w_in_data = vd[i];
            w_in_amt = 5'd31;
            w_in_mode = vm[i];
            step(acc);
            w_in_valid = 1'b0;
            for (int j = 0; j < LAT32 - 2; j++) step(acc);
            checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL w32_%0d_early got out_valid %b expected 0", i, w_out_valid); end
            step(acc);
            checks++; if (w_out_valid !== 1'b1 || {w_out_mode_err, w_out_zero, w_out_data} !== ve[i])
                begin errors++; $display("FAIL w32_%0d_result got v=%b %h expected v=1 %h", i, w_out_valid, {w_out_mode_err, w_out_zero, w_out_data}, ve[i]); end
            step(acc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        test_width32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter WIDTH, default 8: data width; SHALL be a power of two, 4..64.
REQ-002 Parameter AMT_W, default $clog2(WIDTH): shift-amount width; SHALL NOT be overridden.
REQ-003 Derived LAT = AMT_W: pipeline depth in cycles (3 at WIDTH=8).
REQ-004 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_amt  input  AMT_W  shift/rotate amount, 0..WIDTH-1.
REQ-010 in_mode  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  WIDTH  result.
REQ-014 out_zero  output  1  out_data is all zeros.
REQ-015 out_mode_err  output  1  result came from a reserved or compiled-out mode.

Function
REQ-016 Transfer in SHALL occur on a cycle with in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-017 Pipeline SHALL have LAT register stages; stage k SHALL apply a displacement of 2^k when amt bit k is 1, and carry data, mode, remaining amt bits, valid and err with the word.
REQ-018 Stall = out_valid && !out_ready; while stalled all stages SHALL hold and in_ready SHALL be 0; otherwise all stages advance and in_ready SHALL be 1.
REQ-019 An accepted word SHALL appear on out_data exactly LAT cycles after acceptance when no stall occurs; stalls add cycles one-for-one.
REQ-020 Sustained throughput SHALL be one word per cycle with out_ready held high; simultaneous accept-in and accept-out on a full pipeline SHALL lose no word.
REQ-021 Empty stages (bubbles) SHALL advance like valid stages; bubble compression is not required.
REQ-022 SLL/SRL SHALL fill vacated bits with 0; SRA SHALL fill with in_data[WIDTH-1].
REQ-023 ROL/ROR SHALL rotate modulo WIDTH with no bit lost.
REQ-024 in_amt = 0 SHALL return in_data unchanged in every mode.
REQ-025 Reserved modes SHALL return in_data unchanged with out_mode_err = 1; valid modes SHALL give out_mode_err = 0.
REQ-026 out_zero SHALL be registered with the final stage and be coherent with out_data.
REQ-027 out_data, out_zero and out_mode_err SHALL remain stable while out_valid && !out_ready.
REQ-028 Word order SHALL be preserved; no word SHALL be dropped or duplicated.

Reset
REQ-029 Reset SHALL clear all stage valid bits; out_valid = 0, out_data = 0, out_zero = 0, out_mode_err = 0.
REQ-030 in_ready SHALL be 0 during reset and 1 on the first cycle after reset deasserts.
REQ-031 Reset mid-operation SHALL discard every in-flight word; no result from before reset SHALL appear afterwards.
REQ-032 Input presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-033 Macro PIPELINED_SHIFTER_ROTATE_EN defined: ROL/ROR SHALL be implemented per REQ-023.
REQ-034 Macro PIPELINED_SHIFTER_ROTATE_EN undefined: modes 011/100 SHALL be handled as reserved per REQ-025, and no rotate logic SHALL be synthesised.

Verification
REQ-035 WIDTH=8, out_ready=1: SLL 0x81 amt 1 -> 0x02 three cycles later, out_zero=0; SRL 0x80 amt 7 -> 0x01.
REQ-036 SRA 0x90 amt 2 -> 0xE4; SRL 0x01 amt 1 -> 0x00 with out_zero=1.
REQ-037 With ROTATE_EN: ROL 0x81 amt 1 -> 0x03, ROR 0x01 amt 3 -> 0x20; without ROTATE_EN the same inputs -> 0x81/0x01 with out_mode_err=1.
REQ-038 Stream 8 back-to-back words, out_ready low cycles 5-8: in_ready=0 during the stall, outputs held stable, all 8 delivered in order, one per cycle otherwise.
REQ-039 Reset asserted for one cycle with 3 words in flight: out_valid=0 next cycle and no pre-reset word emerges; the first word after reset returns correct at LAT.
REQ-040 Mode 111, amt 5, data 0x5A -> 0x5A, out_mode_err=1; any mode with amt 0 -> data unchanged; repeat REQ-035 at WIDTH=32 with amt 31.
